// File: rtl/pdm_stream_pkg.sv
// Shared types and constants for the PCM-to-UART streaming path: FSM encoding,
// frame geometry and the byte selector used to build each 4-byte frame.
package pdm_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_REQ  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  localparam int         FRAME_BYTES   = 4;
  localparam logic [1:0] LAST_IDX      = 2'(FRAME_BYTES - 1);
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                            input logic [7:0]  sync,
                                            input logic [7:0]  seq,
                                            input logic [15:0] sample);
    case (idx)
      2'd0:    frame_byte = sync;
      2'd1:    frame_byte = seq;
      2'd2:    frame_byte = sample[15:8];
      default: frame_byte = sample[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO: write visible to pop one cycle after push; pop data is combinational from the head.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  // Extra pointer bit distinguishes full (wrapped once) from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/pcm_uart_sched.sv
// Frames buffered PCM samples as SYNC/seq/hi/lo bytes for a go/ready UART; first go 2 cycles after pcm_valid.
// Backpressure: each byte waits for uart_ready low then high; samples beyond DEPTH are dropped and flagged.
module pcm_uart_sched
  import pdm_stream_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  localparam int        LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   pcm,
  input  logic          pcm_valid,
  input  logic          enable,
  input  logic          clear_ovf,
  input  logic          uart_ready,
  output logic [7:0]    uart_char,
  output logic          uart_go,
  output logic          busy,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  char_q, char_d;
  logic        go_q, go_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [15:0] fifo_dat;
  logic        sample_avail;

  sample_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pcm_valid),
    .push_dat (pcm),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // A sample arriving this cycle is already poppable by the LOAD that follows.
  assign sample_avail = !fifo_empty || pcm_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      frame_q <= '0;
      char_q  <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      frame_q <= frame_d;
      char_q  <= char_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    frame_d  = frame_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: if (sample_avail && enable && uart_ready) state_d = ST_LOAD;
      ST_LOAD: begin
        fifo_pop = 1'b1;
        frame_d  = fifo_dat;
        idx_d    = '0;
        state_d  = ST_REQ;
      end
      ST_REQ:  if (!uart_ready) state_d = ST_ACK;
      ST_ACK: begin
        if (uart_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_REQ;
          end else begin
            seq_d   = seq_q + 8'd1;
            state_d = (sample_avail && enable) ? ST_LOAD : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port is a plain flop.
  always_comb begin
    go_d   = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
    char_d = char_q;
    if (state_d == ST_REQ && state_q != ST_REQ)
      char_d = frame_byte(idx_d, SYNC_BYTE, seq_q, frame_d);
    ovf_d = (pcm_valid && fifo_full && !fifo_pop) || (ovf_q && !clear_ovf);
  end

  assign uart_char = char_q;
  assign uart_go   = go_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule
